// File: rtl/clock_ratio_meter.sv
// Measures period and high time of clk_div in clk_in cycles, one-shot on start.
// Optional CLK_RATIO_SYNC_EN: 2-flop synchronizer on clk_div (else a single register).
module clock_ratio_meter #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic             clk_in,
  input  logic             nrst,
  input  logic             clk_div,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic             timeout,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_MEAS,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  state_t           r_state;
  logic             r_s;
  logic             r_s_q;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_high;
  logic             r_fall_seen;

  logic             w_rise;
  logic             w_fall;
  logic             w_limit;
  logic [CNT_W-1:0] w_cnt_inc;

`ifdef CLK_RATIO_SYNC_EN
  logic r_meta;

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      r_meta <= 1'b0;
      r_s    <= 1'b0;
    end else begin
      r_meta <= clk_div;
      r_s    <= r_meta;
    end
  end
`else
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      r_s <= 1'b0;
    end else begin
      r_s <= clk_div;
    end
  end
`endif

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      r_s_q <= 1'b0;
    end else begin
      r_s_q <= r_s;
    end
  end

  assign w_rise    = r_s & ~r_s_q;
  assign w_fall    = ~r_s & r_s_q;
  assign w_limit   = (r_cnt == LIMIT);
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_high      <= '0;
      r_fall_seen <= 1'b0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      timeout     <= 1'b0;
      period      <= '0;
      high_time   <= '0;
    end else begin
      valid   <= 1'b0;
      timeout <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
            busy    <= 1'b1;
          end
        end
        S_WAIT: begin
          if (w_rise) begin
            r_state     <= S_MEAS;
            r_cnt       <= '0;
            r_fall_seen <= 1'b0;
          end else if (w_limit) begin
            r_state   <= S_IDLE;
            busy      <= 1'b0;
            timeout   <= 1'b1;
            period    <= '0;
            high_time <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_MEAS: begin
          // a rise on the limit cycle still completes the measurement
          if (w_rise) begin
            r_state   <= S_DONE;
            busy      <= 1'b0;
            valid     <= 1'b1;
            period    <= w_cnt_inc;
            high_time <= r_fall_seen ? r_high : '0;
          end else if (w_limit) begin
            r_state   <= S_IDLE;
            busy      <= 1'b0;
            timeout   <= 1'b1;
            period    <= '0;
            high_time <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_fall && !r_fall_seen) begin
              r_high      <= w_cnt_inc;
              r_fall_seen <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Bench for clock_ratio_meter: vector table, reset/second-start sequences,
// and random clk_div shapes against an edge-list reference model.
module tb_clock_ratio_meter;

  localparam int W  = 16;
  localparam int TO = 20;
`ifdef CLK_RATIO_SYNC_EN
  localparam int D = 1;
`else
  localparam int D = 0;
`endif

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         clk_div = 1'b0;
  logic         start = 1'b0;
  logic         busy;
  logic         valid;
  logic         timeout;
  logic [W-1:0] period;
  logic [W-1:0] high_time;

  always #5 clk = ~clk;

  clock_ratio_meter #(
    .CNT_W      (W),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk_in   (clk),
    .nrst     (nrst),
    .clk_div  (clk_div),
    .start    (start),
    .busy     (busy),
    .valid    (valid),
    .timeout  (timeout),
    .period   (period),
    .high_time(high_time)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit wave [0:16383];

  int g_mode = 1;
  int g_hi = 1;
  int g_lo = 1;
  int g_ph = 0;
  bit g_cval = 1'b0;

  typedef struct {
    int mode;
    int hi;
    int lo;
    bit cval;
    bit second;
    int eper;
    int ehi;
    int eto;
  } vec_t;

  vec_t tbl [9];

  function automatic bit gen(input int t);
    if (g_mode == 1) return g_cval;
    return ((t + g_ph) % (g_hi + g_lo)) < g_hi;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    clk_div = gen(cyc);
    wave[cyc] = clk_div;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic bit is_rise(input int t);
    return wave[t] && !wave[t-1];
  endfunction

  function automatic bit is_fall(input int t);
    return !wave[t] && wave[t-1];
  endfunction

  // Works on the recorded edge list: distances between sampled edges,
  // plus the fixed detect latency to place the result pulse in time.
  task automatic model(input int t0, output int eto, output int eev,
                       output int eper, output int ehi);
    int r0;
    int r1;
    int f;
    r0 = -1;
    r1 = -1;
    f = -1;
    eper = 0;
    ehi = 0;
    for (int t = t0 - D; t <= t0 + TO - 1 - D; t++) begin
      if (r0 < 0 && is_rise(t)) r0 = t;
    end
    if (r0 < 0) begin
      eto = 1;
      eev = t0 + TO + 1;
      return;
    end
    for (int t = r0 + 1; t <= r0 + TO; t++) begin
      if (r1 < 0 && is_rise(t)) r1 = t;
    end
    if (r1 < 0) begin
      eto = 1;
      eev = r0 + D + TO + 2;
      return;
    end
    for (int t = r0 + 1; t < r1; t++) begin
      if (f < 0 && is_fall(t)) f = t;
    end
    eto = 0;
    eev = r1 + D + 2;
    eper = r1 - r0;
    ehi = (f > 0) ? f - r0 : 0;
  endtask

  task automatic run_meas(input int mode, input int hi, input int lo,
                          input int ph, input bit cval, input bit second,
                          input string tag, output int per, output int ht,
                          output int to);
    int t0;
    int nv;
    int nt;
    int ev;
    int bz;
    int eto;
    int eev;
    int eper;
    int ehi;
    g_mode = mode;
    g_hi = hi;
    g_lo = lo;
    g_ph = ph;
    g_cval = cval;
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    t0 = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    nv = 0;
    nt = 0;
    ev = -1;
    bz = -1;
    per = -1;
    ht = -1;
    to = 0;
    for (int k = 0; k < 100; k++) begin
      start = second && (k == 3);
      step();
      start = 1'b0;
      if (valid && timeout) check({tag, ".both"}, 1, 0);
      if (valid || timeout) begin
        if (valid) nv++;
        if (timeout) nt++;
        if (ev < 0) begin
          ev = cyc;
          bz = busy;
          per = period;
          ht = high_time;
          to = timeout;
        end
      end
    end
    model(t0, eto, eev, eper, ehi);
    check({tag, ".nvalid"}, nv, eto ? 0 : 1);
    check({tag, ".ntimeout"}, nt, eto);
    check({tag, ".evcyc"}, ev, eev);
    check({tag, ".period"}, per, eper);
    check({tag, ".high"}, ht, ehi);
    check({tag, ".busy_at_ev"}, bz, 0);
    check({tag, ".hold"}, int'(period), eper);
  endtask

  initial begin
    int per;
    int ht;
    int to;
    int nv;
    int nt;

    tbl[0] = '{0, 3, 3, 1'b0, 1'b0, 6, 3, 0};
    tbl[1] = '{0, 1, 1, 1'b0, 1'b0, 2, 1, 0};
    tbl[2] = '{1, 1, 1, 1'b0, 1'b0, 0, 0, 1};
    tbl[3] = '{0, 5, 2, 1'b0, 1'b0, 7, 5, 0};
    tbl[4] = '{1, 1, 1, 1'b1, 1'b0, 0, 0, 1};
    tbl[5] = '{0, 10, 10, 1'b0, 1'b0, 20, 10, 0};
    tbl[6] = '{0, 1, 19, 1'b0, 1'b0, 20, 1, 0};
    tbl[7] = '{0, 3, 3, 1'b0, 1'b1, 6, 3, 0};
    tbl[8] = '{0, 15, 10, 1'b0, 1'b0, 0, 0, 1};

    #12;
    check("rst.busy", busy, 0);
    check("rst.valid", valid, 0);
    check("rst.timeout", timeout, 0);
    check("rst.period", period, 0);
    check("rst.high", high_time, 0);
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_meas(tbl[i].mode, tbl[i].hi, tbl[i].lo, 0, tbl[i].cval,
               tbl[i].second, $sformatf("vec%0d", i), per, ht, to);
      check($sformatf("vec%0d.tbl_period", i), per, tbl[i].eper);
      check($sformatf("vec%0d.tbl_high", i), ht, tbl[i].ehi);
      check($sformatf("vec%0d.tbl_to", i), to, tbl[i].eto);
    end

    // abort a running measurement with reset, then measure again
    g_mode = 0;
    g_hi = 3;
    g_lo = 3;
    g_ph = 0;
    for (int i = 0; i < 4; i++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("abort.busy_before", busy, 1);
    #2;
    nrst = 1'b0;
    #1;
    check("abort.busy", busy, 0);
    check("abort.valid", valid, 0);
    check("abort.timeout", timeout, 0);
    check("abort.period", period, 0);
    check("abort.high", high_time, 0);
    #1;
    nrst = 1'b1;
    nv = 0;
    nt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (valid) nv++;
      if (timeout) nt++;
    end
    check("abort.no_valid", nv, 0);
    check("abort.no_timeout", nt, 0);
    run_meas(0, 5, 2, 3, 1'b0, 1'b0, "after_abort", per, ht, to);
    check("after_abort.period", per, 7);
    check("after_abort.high", ht, 5);

    for (int i = 0; i < 30; i++) begin
      run_meas(0, $urandom_range(1, 12), $urandom_range(1, 12),
               $urandom_range(0, 23), 1'b0, 1'($urandom_range(0, 1)),
               $sformatf("rnd%0d", i), per, ht, to);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
